// File: rtl/egress_arbiter.sv
// egress_arbiter: weighted round-robin drain of four output FIFOs into a
// 2-entry valid/ready buffer, plus saturating per-class transfer counters.
module egress_arbiter #(
  parameter int DATA_SIZE = 12,
  parameter int WEIGHT_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [WEIGHT_W-1:0]  weight0,
  input  logic [WEIGHT_W-1:0]  weight1,
  input  logic [WEIGHT_W-1:0]  weight2,
  input  logic [WEIGHT_W-1:0]  weight3,
  input  logic                 empty0,
  input  logic                 empty1,
  input  logic                 empty2,
  input  logic                 empty3,
  input  logic [DATA_SIZE-1:0] data_in0,
  input  logic [DATA_SIZE-1:0] data_in1,
  input  logic [DATA_SIZE-1:0] data_in2,
  input  logic [DATA_SIZE-1:0] data_in3,
  output logic                 pop0,
  output logic                 pop1,
  output logic                 pop2,
  output logic                 pop3,
  output logic [DATA_SIZE-1:0] data_out,
  output logic [1:0]           class_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  input  logic                 req,
  input  logic [1:0]           idx,
  output logic [4:0]           cnt_out,
  output logic                 cnt_valid
);

  localparam logic [0:0]          ST_INIT   = 1'b0;
  localparam logic [0:0]          ST_ACTIVE = 1'b1;
  localparam logic [WEIGHT_W-1:0] W_ONE     = WEIGHT_W'(1);
  localparam logic [4:0]          CNT_MAX   = 5'd31;

  logic [WEIGHT_W-1:0]  weight_w [4];
  logic [DATA_SIZE-1:0] data_w   [4];
  logic [3:0]           empty_w;
  logic [3:0]           pop_w;

  assign weight_w[0] = weight0;
  assign weight_w[1] = weight1;
  assign weight_w[2] = weight2;
  assign weight_w[3] = weight3;
  assign data_w[0]   = data_in0;
  assign data_w[1]   = data_in1;
  assign data_w[2]   = data_in2;
  assign data_w[3]   = data_in3;
  assign empty_w     = {empty3, empty2, empty1, empty0};
  assign pop0        = pop_w[0];
  assign pop1        = pop_w[1];
  assign pop2        = pop_w[2];
  assign pop3        = pop_w[3];

  logic [0:0]           state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;
  logic [WEIGHT_W-1:0]  wt_q [4];
  logic [WEIGHT_W-1:0]  wt_d [4];
  logic                 rd_pending_q, rd_pending_d;
  logic [1:0]           rd_src_q, rd_src_d;
  logic [1:0]           occ_q, occ_d;
  logic [DATA_SIZE-1:0] buf_data_q [2];
  logic [DATA_SIZE-1:0] buf_data_d [2];
  logic [1:0]           buf_cls_q [2];
  logic [1:0]           buf_cls_d [2];
  logic [4:0]           cnt_q [4];
  logic [4:0]           cnt_d [4];
  logic [4:0]           cnt_out_q, cnt_out_d;
  logic                 cnt_valid_q, cnt_valid_d;

  logic       active;
  logic       xfer;
  logic       space;
  logic       pop_en;
  logic [2:0] fill;
  logic       nxt_found;
  logic [1:0] nxt_grant;
  logic [1:0] cand;

  assign valid_out = (occ_q != 2'd0);
  assign data_out  = buf_data_q[0];
  assign class_out = buf_cls_q[0];
  assign cnt_out   = cnt_out_q;
  assign cnt_valid = cnt_valid_q;

  // Pops are gated by the live init input so entering configuration stops them at once.
  assign active = (state_q == ST_ACTIVE) && !init;
  assign xfer   = valid_out && ready_in;
  assign fill   = {1'b0, occ_q} + {2'b00, rd_pending_q};
  assign space  = fill < (3'd2 + {2'b00, xfer});
  assign pop_en = active && !empty_w[grant_q] && space;

  // First non-empty class after the current grant, wrapping back to the grant itself.
  always_comb begin
    nxt_found = 1'b0;
    nxt_grant = grant_q;
    cand      = grant_q;
    for (int k = 1; k <= 4; k++) begin
      cand = grant_q + 2'(k);
      if (!nxt_found && !empty_w[cand]) begin
        nxt_found = 1'b1;
        nxt_grant = cand;
      end
    end
  end

  always_comb begin
    state_d      = init ? ST_INIT : ST_ACTIVE;
    grant_d      = grant_q;
    credit_d     = credit_q;
    rd_pending_d = pop_en;
    rd_src_d     = pop_en ? grant_q : rd_src_q;
    if (state_q == ST_INIT || init) begin
      grant_d  = 2'd0;
      credit_d = wt_q[0];
    end else begin
      if (pop_en)
        credit_d = credit_q - W_ONE;
      if (((pop_en && credit_q == W_ONE) || empty_w[grant_q]) && nxt_found) begin
        grant_d  = nxt_grant;
        credit_d = wt_q[nxt_grant];
      end
    end
  end

  // Entry 0 is always the head; entry 1 shifts down when the head is consumed.
  always_comb begin
    occ_d         = occ_q;
    buf_data_d[0] = buf_data_q[0];
    buf_data_d[1] = buf_data_q[1];
    buf_cls_d[0]  = buf_cls_q[0];
    buf_cls_d[1]  = buf_cls_q[1];
    case ({rd_pending_q, xfer})
      2'b01: begin
        buf_data_d[0] = buf_data_q[1];
        buf_cls_d[0]  = buf_cls_q[1];
        occ_d         = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf_data_d[0] = data_w[rd_src_q];
          buf_cls_d[0]  = rd_src_q;
        end else begin
          buf_data_d[1] = data_w[rd_src_q];
          buf_cls_d[1]  = rd_src_q;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf_data_d[0] = data_w[rd_src_q];
          buf_cls_d[0]  = rd_src_q;
        end else begin
          buf_data_d[0] = buf_data_q[1];
          buf_cls_d[0]  = buf_cls_q[1];
          buf_data_d[1] = data_w[rd_src_q];
          buf_cls_d[1]  = rd_src_q;
        end
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_class
      assign pop_w[gi] = pop_en && (grant_q == 2'(gi));
      assign wt_d[gi]  = init ? ((weight_w[gi] == '0) ? W_ONE : weight_w[gi]) : wt_q[gi];
      assign cnt_d[gi] = init ? 5'd0 :
                         (xfer && class_out == 2'(gi) && cnt_q[gi] != CNT_MAX) ? cnt_q[gi] + 5'd1 :
                         cnt_q[gi];
    end
  endgenerate

  // Read returns the count as it stood before this edge's increment.
  assign cnt_valid_d = req;
  assign cnt_out_d   = req ? cnt_q[idx] : cnt_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      grant_q      <= 2'd0;
      credit_q     <= '0;
      rd_pending_q <= 1'b0;
      rd_src_q     <= 2'd0;
      occ_q        <= 2'd0;
      cnt_out_q    <= 5'd0;
      cnt_valid_q  <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        buf_data_q[k] <= '0;
        buf_cls_q[k]  <= 2'd0;
      end
      for (int k = 0; k < 4; k++) begin
        wt_q[k]  <= W_ONE;
        cnt_q[k] <= 5'd0;
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      credit_q     <= credit_d;
      rd_pending_q <= rd_pending_d;
      rd_src_q     <= rd_src_d;
      occ_q        <= occ_d;
      cnt_out_q    <= cnt_out_d;
      cnt_valid_q  <= cnt_valid_d;
      for (int k = 0; k < 2; k++) begin
        buf_data_q[k] <= buf_data_d[k];
        buf_cls_q[k]  <= buf_cls_d[k];
      end
      for (int k = 0; k < 4; k++) begin
        wt_q[k]  <= wt_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

endmodule
